// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 (MSB first) responder that gives a host
// byte-wide read/write access to a register bank. SCK, CSB and SDI are
// oversampled in the core clock domain, so the block has no SPI-clock flops.
// Optional feature: define SPI_RESP_AUTOINC_EN to advance reg_addr after every
// data byte. Without it, the address stays fixed for the whole transaction.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              spi_csb,
  input  logic              spi_sck,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oeb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DROP} state_t;

  logic [SYNC_STAGES-1:0] csb_sync, sck_sync, sdi_sync;
  logic                   csb_d, sck_d, sdi_d;
  logic                   sck_rise, sck_fall, csb_rise, csb_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_in;
  logic [7:0]             byte_in, shift_out, wdata_q;
  logic                   cmd_wr, cmd_rd, load_q;
  logic                   bc, we_c, re_n, cmd_load, addr_load, addr_step;
  logic                   sdo_en;
  logic [ADDR_W-1:0]      addr_byte;
  state_t                 state_q, state_n;

  // Synchronizer chains; CSB history resets to "selected" so a host still
  // holding CSB low across reset is ignored until it deselects once.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      csb_sync <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
    end
  end

  // Registered edge pulses; csb_d/sdi_d line up with the pulse cycle.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      csb_d    <= 1'b0;
      sck_d    <= 1'b0;
      sdi_d    <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      csb_rise <= 1'b0;
      csb_fall <= 1'b0;
    end else begin
      csb_d    <= csb_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
      sdi_d    <= sdi_sync[SYNC_STAGES-1];
      sck_rise <=  sck_sync[SYNC_STAGES-1] & ~sck_d;
      sck_fall <= ~sck_sync[SYNC_STAGES-1] &  sck_d;
      csb_rise <=  csb_sync[SYNC_STAGES-1] & ~csb_d;
      csb_fall <= ~csb_sync[SYNC_STAGES-1] &  csb_d;
    end
  end

  // The eighth bit is taken straight from the aligned SDI sample, so only
  // seven bits of history need storing.
  assign byte_in = {shift_in, sdi_d};
  assign bc      = sck_rise & ~csb_d & (bit_cnt == 3'd7);

  generate
    if (ADDR_W > 8) begin : g_addr_wide
      assign addr_byte = {{(ADDR_W-8){1'b0}}, byte_in};
    end else begin : g_addr_narrow
      assign addr_byte = byte_in[ADDR_W-1:0];
    end
  endgenerate

  // Bit counter and shift-in register; any CSB edge restarts byte framing.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
    end else if (csb_fall || csb_rise) begin
      bit_cnt  <= 3'd0;
    end else if (sck_rise && !csb_d) begin
      bit_cnt  <= bit_cnt + 3'd1;
      shift_in <= byte_in[6:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_n;
  end

  // Next-state and per-byte strobe decode; deselect overrides everything.
  always_comb begin
    state_n   = state_q;
    we_c      = 1'b0;
    re_n      = 1'b0;
    cmd_load  = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    case (state_q)
      IDLE: if (csb_fall) state_n = CMD;
      CMD: if (bc) begin
        cmd_load = 1'b1;
        state_n  = (byte_in[7] || byte_in[6]) ? ADDR : DROP;
      end
      ADDR: if (bc) begin
        addr_load = 1'b1;
        re_n      = cmd_rd;
        state_n   = DATA;
      end
      DATA: if (bc) begin
        we_c = cmd_wr;
        re_n = cmd_rd;
`ifdef SPI_RESP_AUTOINC_EN
        addr_step = 1'b1;
`else
        addr_step = 1'b0;
`endif
      end
      DROP: state_n = DROP;
      default: state_n = IDLE;
    endcase
    if (csb_rise) begin
      state_n   = IDLE;
      we_c      = 1'b0;
      re_n      = 1'b0;
      cmd_load  = 1'b0;
      addr_load = 1'b0;
      addr_step = 1'b0;
    end
  end

  // Register-side datapath: command flags, address, read strobe and the
  // SDO shifter. The fall that follows a byte's eighth rise (bit_cnt back
  // at 0) must not shift, since the next byte's MSB was just loaded.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      reg_re    <= 1'b0;
      load_q    <= 1'b0;
      reg_addr  <= '0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      wdata_q   <= 8'd0;
      shift_out <= 8'd0;
    end else begin
      reg_re <= re_n;
      load_q <= reg_re;
      if (cmd_load) begin
        cmd_wr <= byte_in[7];
        cmd_rd <= byte_in[6];
      end
      if (addr_load)      reg_addr <= addr_byte;
      else if (addr_step) reg_addr <= reg_addr + ADDR_W'(1);
      if (we_c) wdata_q <= byte_in;
      if (load_q)
        shift_out <= reg_rdata;
      else if (sck_fall && !csb_d && state_q == DATA && bit_cnt != 3'd0)
        shift_out <= {shift_out[6:0], 1'b0};
    end
  end

  assign reg_we      = we_c;
  assign reg_wdata   = we_c ? byte_in : wdata_q;
  assign sdo_en      = (state_q == DATA) && cmd_rd && !csb_d;
  assign spi_sdo_oeb = ~sdo_en;
  assign spi_sdo     = sdo_en & (load_q ? reg_rdata[7] : shift_out[7]);
  assign busy        = ~csb_d & (state_q != IDLE);

endmodule

// File: doc/spi_reg_responder.md
# spi_reg_responder

SPI responder (mode 0, MSB first) that gives an external SPI host byte-wide read/write access to a management register file through the user GPIO pads. SCK, CSB and SDI are oversampled in the core `clock` domain, so the block has no SPI-clock flops. It sits in the core between the `mprj_io` pad inputs/outputs and the housekeeping register bank.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `spi_csb`, `spi_sck` and `spi_sdi` (minimum 2).
- `ADDR_W`, 8: register address width.

Ports:
- `clock`  in  1  core clock; only clock in the block.
- `resetb`  in  1  reset, synchronous and active-low.
- `spi_csb`  in  1  chip select, active low, asynchronous to `clock`.
- `spi_sck`  in  1  SPI clock, asynchronous.
- `spi_sdi`  in  1  serial data from host.
- `spi_sdo`  out  1  serial data to host.
- `spi_sdo_oeb`  out  1  pad output-enable bar for SDO; 0 = drive.
- `reg_addr`  out  ADDR_W  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  write strobe, one cycle.
- `reg_re`  out  1  read strobe, one cycle.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.
- `busy`  out  1  high while CSB is low (synchronized) and the FSM is not IDLE.

## Operation
- Synchronized inputs drive edge detectors. An SCK rise samples SDI into an 8-bit shift-in register. An SCK fall shifts SDO out of a shift-out register. The 3-bit bit counter resets on CSB fall.
- FSM states:
  - IDLE: entered on CSB fall, go to CMD.
  - CMD: 8 bits are received. bit7 = write, bit6 = read, bits[5:0] are ignored. If neither bit7 nor bit6 is set, go to DROP; otherwise go to ADDR.
  - ADDR: 8 bits are received into `reg_addr` (upper bits zero if ADDR_W>8; truncated if <8). Go to DATA.
  - DATA: repeating byte transfers.
  - DROP: ignore everything until CSB rises.
- Any state goes to IDLE on synchronized CSB rise.
- Byte-complete event `bc`: the cycle the 8th SCK rise of a byte is detected.
  - On ADDR `bc`, if read: `reg_re` is pulsed on cycle bc+1.
  - On DATA `bc`, if write: on cycle bc, `reg_we`=1, `reg_wdata`=shift-in value, at the current `reg_addr`.
  - On cycle bc+1, `reg_addr` advances (see Configuration). If read, `reg_re` is pulsed in the same cycle with the new address.
- Read data: `reg_rdata` is loaded into the shift-out register on the cycle after `reg_re`. Bit7 goes onto `spi_sdo` immediately. Each later SCK fall shifts out the next bit.
- Read+write (0xC0): the byte at A is shifted out while the new byte for A is shifted in. A is written at `bc`, then A+1 is read.
- `spi_sdo_oeb`=0 only in DATA with the read bit set and CSB low. Otherwise it is 1 and `spi_sdo`=0.
- CSB rise mid-byte: the partial byte is discarded, with no `reg_we`/`reg_re`. The bit counter clears and the FSM returns to IDLE.
- Address wraps 2^ADDR_W-1 to 0.

## Timing
- Reset values: `spi_sdo`=0, `spi_sdo_oeb`=1, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, FSM=IDLE. Reset asserted mid-transfer clears everything on the next `clock` edge, with no partial strobes.
- Input-to-detect latency: SYNC_STAGES+1 cycles.
- Host constraints:
  - SCK high and low phases ≥ SYNC_STAGES+4 `clock` periods each.
  - CSB setup to the first SCK rise ≥ SYNC_STAGES+2 cycles.
  - CSB high time ≥ SYNC_STAGES+2 cycles.
- First SDO bit of each byte is valid SYNC_STAGES+3 cycles after the SCK rise that completed the previous byte. This is before the next SCK fall given the constraint above.
- `reg_we` and `reg_re` are never high in the same cycle.

## Configuration
- `SPI_RESP_AUTOINC_EN` defined: `reg_addr` increments by 1 after every DATA byte (streaming across registers).
- Not defined: `reg_addr` holds the ADDR value for the whole transaction. Repeated bytes read or write the same register (FIFO-port style). `reg_re` is still pulsed per byte.

## Test plan
- Reset: hold `resetb`=0 for 3 cycles with SCK toggling → all outputs at their reset values, no strobes.
- Write stream: CSB low, send 0x80, 0x10, 0xA5, 0x3C, CSB high → `reg_we` at 0x10 with wdata 0xA5, then at 0x11 with 0x3C. Without the macro, both writes go to 0x10.
- Read stream: regfile 0x20=0x5A, 0x21=0xC3. Send 0x40, 0x20, then 16 SCK → SDO bits 0x5A then 0xC3 MSB first, `spi_sdo_oeb`=0 during DATA, `reg_re` at 0x20, then 0x21 (or 0x20 twice without the macro).
- Read+write: send 0xC0, 0x05, 0x77 with 0x05 holding 0x11 → SDO shifts 0x11, then `reg_we` at 0x05 with data 0x77, then `reg_re` at 0x06.
- Abort/no-op: send 0x80, 0x30, 4 bits, then CSB high → no `reg_we`, FSM IDLE, `busy`=0. Command 0x00 → DROP state, no strobes, `spi_sdo_oeb` stays 1.
- Wrap: ADDR=0xFF, write 2 bytes with the macro defined → writes at 0xFF, then at 0x00.
